// File: rtl/demux_1bit_deser_if.sv
// rtl/demux_1bit_deser_if.sv - serial-in / parallel-out bus for the 1-bit deserializing demux
// Optional out_parity signal present when DEMUX_PARITY_EN is defined.
interface demux_1bit_deser_if #(
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2,
  parameter int WORD_W  = 8
);
  logic                      data_in;
  logic                      in_valid;
  logic [SEL_W-1:0]          select;
  logic                      flush;
  logic [NUM_OUT*WORD_W-1:0] data_out;
  logic [NUM_OUT-1:0]        out_valid;
  logic                      err_sel;
`ifdef DEMUX_PARITY_EN
  logic [NUM_OUT-1:0]        out_parity;

  modport master (output data_in, in_valid, select, flush,
                  input  data_out, out_valid, err_sel, out_parity);
  modport slave  (input  data_in, in_valid, select, flush,
                  output data_out, out_valid, err_sel, out_parity);
`else
  modport master (output data_in, in_valid, select, flush,
                  input  data_out, out_valid, err_sel);
  modport slave  (input  data_in, in_valid, select, flush,
                  output data_out, out_valid, err_sel);
`endif
endinterface

// File: rtl/demux_1bit_deser.sv
// rtl/demux_1bit_deser.sv - steers a serial bit stream into NUM_OUT independent MSB-first deserializers
// Optional per-channel even-parity output enabled by DEMUX_PARITY_EN.
module demux_1bit_deser #(
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2,
  parameter int WORD_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  demux_1bit_deser_if.slave  bus
);
  localparam int               CNT_W     = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [SEL_W:0]   NUM_OUT_X = (SEL_W + 1)'(NUM_OUT);

  logic [WORD_W-1:0]         sh_q  [NUM_OUT];
  logic [WORD_W-1:0]         sh_d  [NUM_OUT];
  logic [CNT_W-1:0]          cnt_q [NUM_OUT];
  logic [CNT_W-1:0]          cnt_d [NUM_OUT];
  logic [NUM_OUT*WORD_W-1:0] data_out_q, data_out_d;
  logic [NUM_OUT-1:0]        out_valid_q, out_valid_d;
  logic                      err_sel_q, err_sel_d;
  logic [NUM_OUT-1:0]        parity_q, parity_d;
  logic [WORD_W-1:0]         word;
  logic                      sel_ok;

  // Extra top bit keeps the compare correct when 2^SEL_W == NUM_OUT.
  assign sel_ok = ({1'b0, bus.select} < NUM_OUT_X);

  always_comb begin
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    parity_d    = parity_q;
    out_valid_d = '0;
    err_sel_d   = 1'b0;
    word        = '0;
    if (bus.flush) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        sh_d[k]  = '0;
        cnt_d[k] = '0;
      end
    end else if (bus.in_valid) begin
      if (!sel_ok) begin
        err_sel_d = 1'b1;
      end else begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (bus.select == SEL_W'(k)) begin
            word    = {sh_q[k][WORD_W-2:0], bus.data_in};
            sh_d[k] = word;
            if (cnt_q[k] == CNT_LAST) begin
              cnt_d[k]                        = '0;
              data_out_d[k*WORD_W +: WORD_W]  = word;
              parity_d[k]                     = ^word;
              out_valid_d[k]                  = 1'b1;
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        sh_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
      data_out_q  <= '0;
      parity_q    <= '0;
      out_valid_q <= '0;
      err_sel_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        sh_q[k]  <= sh_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      data_out_q  <= data_out_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
      err_sel_q   <= err_sel_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err_sel   = err_sel_q;
`ifdef DEMUX_PARITY_EN
  assign bus.out_parity = parity_q;
`else
  logic unused_parity;
  assign unused_parity = ^parity_q;
`endif
endmodule

// File: tb/tb_demux_1bit_deser.sv
// tb/tb_demux_1bit_deser.sv - scoreboard bench for demux_1bit_deser (directed cases plus random traffic)
module tb_demux_1bit_deser;
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 3;
  localparam int WORD_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_1bit_deser_if #(.NUM_OUT(NUM_OUT), .SEL_W(SEL_W), .WORD_W(WORD_W)) bus ();
  demux_1bit_deser #(.NUM_OUT(NUM_OUT), .SEL_W(SEL_W), .WORD_W(WORD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                        cyc;
    logic [NUM_OUT-1:0]        valid;
    logic                      err;
    logic [NUM_OUT*WORD_W-1:0] data;
    logic [NUM_OUT-1:0]        par;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: per-channel accumulated value and bit count, plus last loaded word.
  longint unsigned acc    [NUM_OUT];
  int              nbits  [NUM_OUT];
  longint unsigned word_m [NUM_OUT];
  int              par_m  [NUM_OUT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NUM_OUT; k++) begin
      acc[k] = 0; nbits[k] = 0; word_m[k] = 0; par_m[k] = 0;
    end
  endfunction

  task automatic step(input int v, input int b, input int s, input int f);
    exp_t e;
    @(negedge clk);
    #1;
    bus.in_valid = v[0];
    bus.data_in  = b[0];
    bus.select   = SEL_W'(s);
    bus.flush    = f[0];
    e.valid = '0;
    e.err   = 1'b0;
    if (f != 0) begin
      for (int k = 0; k < NUM_OUT; k++) begin acc[k] = 0; nbits[k] = 0; end
    end else if (v != 0) begin
      if (s >= NUM_OUT) e.err = 1'b1;
      else begin
        acc[s]   = acc[s] * 2 + longint'(b);
        nbits[s] = nbits[s] + 1;
        if (nbits[s] == WORD_W) begin
          word_m[s]  = acc[s];
          par_m[s]   = $countones(acc[s]) % 2;
          e.valid[s] = 1'b1;
          acc[s]     = 0;
          nbits[s]   = 0;
        end
      end
    end
    if (e.valid != 0 || e.err) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        e.data[k*WORD_W +: WORD_W] = WORD_W'(word_m[k]);
        e.par[k]                   = par_m[k][0];
      end
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input int ch, input int w);
    for (int i = WORD_W - 1; i >= 0; i--) step(1, (w >> i) & 1, ch, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("out_valid", 64'(bus.out_valid), 64'(e.valid));
      chk("err_sel",   64'(bus.err_sel),   64'(e.err));
      chk("data_out",  64'(bus.data_out),  64'(e.data));
`ifdef DEMUX_PARITY_EN
      chk("out_parity", 64'(bus.out_parity), 64'(e.par));
`endif
    end else if (bus.out_valid != 0 || bus.err_sel) begin
      chk("spurious_pulse", 64'({bus.out_valid, bus.err_sel}), 64'(0));
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.data_in  = 1'b0;
    bus.select   = '0;
    bus.flush    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_data_out",  64'(bus.data_out),  64'(0));
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_err_sel",   64'(bus.err_sel),   64'(0));
    rst = 1'b0;

    // Load a nonzero word, then reset mid-word on ch0.
    send_word(2, 'h5A);
    idle(2);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    idle(1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_data_out",  64'(bus.data_out),  64'(0));
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("async_rst_err_sel",   64'(bus.err_sel),   64'(0));
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    send_word(0, 'hA5);
    idle(2);

    // Interleave: half word on ch1, full word on ch2, rest of ch1.
    step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0);
    send_word(2, 'hFF);
    step(1, 0, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    idle(2);

    send_word(3, 'h3C);
    send_word(3, 'h81);
    idle(2);

    // Flush with a simultaneous valid bit.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    send_word(0, 'h5A);
    idle(2);

    step(1, 1, 5, 0);
    step(1, 0, 7, 0);
    send_word(0, 'hC7);
    idle(2);

    send_word(1, 'h07);
    send_word(1, 'h03);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      int s;
      s = ($urandom_range(0, 9) == 0) ? 4 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      step(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)), s,
           int'($urandom_range(0, 49) == 0));
    end
    idle(4);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/demux_1bit_deser.md
Name: demux_1bit_deser

Overview:
- Sequential counterpart to the team's 1-bit 2:1 mux: takes one serial bit stream and steers each valid bit to one of NUM_OUT channels by a select index.
- Each channel holds an independent deserializer that assembles WORD_W bits into a registered parallel word and pulses a per-channel valid flag.
- Sits between the serial input front end and the parallel consumers of game/control data.

Parameters:
- NUM_OUT, 4, number of output channels (2..16).
- SEL_W, 2, width of select; must satisfy 2^SEL_W >= NUM_OUT.
- WORD_W, 8, bits per assembled word (2..32).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  1  serial data bit.
- in_valid  input  1  data_in is valid and is consumed this cycle.
- select  input  SEL_W  destination channel index for the current bit.
- flush  input  1  synchronous clear of all partial words.
- data_out  output  NUM_OUT*WORD_W  registered words; channel k occupies bits [k*WORD_W +: WORD_W].
- out_valid  output  NUM_OUT  one-cycle pulse per channel when a new word is loaded.
- err_sel  output  1  one-cycle pulse when a valid bit has select >= NUM_OUT.

Behaviour:
- Reset (rst=1, asynchronous): all shift registers, bit counters, data_out, out_valid and err_sel are 0. Reset mid-word discards partial words. No pulses are emitted on reset release.
- Per-channel state: a WORD_W-bit shift register sh[k] and a bit counter cnt[k] in the range 0..WORD_W-1.
- Bit accept: when in_valid=1, flush=0 and select=k<NUM_OUT:
  - sh[k] <= {sh[k][WORD_W-2:0], data_in}, so the word is MSB-first.
  - cnt[k] increments.
- Word complete: when a bit is accepted while cnt[k]==WORD_W-1:
  - data_out word k <= {sh[k][WORD_W-2:0], data_in}.
  - out_valid[k]=1 in the next cycle only.
  - cnt[k] <= 0. Latency: the word is visible 1 cycle after its last bit is accepted.
- Back-to-back words on one channel: the next word can start in the cycle after the last bit, with no bubble required. out_valid may pulse on consecutive word boundaries only.
- Channel independence: only the selected channel changes. Switching select mid-word keeps the other channels' partial state intact, and they resume when reselected.
- in_valid=0: no state change; out_valid and err_sel are 0.
- Out-of-range select (select >= NUM_OUT with in_valid=1): the bit is dropped, no counter changes, and err_sel=1 next cycle for one cycle.
- flush=1:
  - All sh and cnt are cleared next cycle.
  - data_out is unchanged.
  - No out_valid is emitted.
  - flush has priority over a simultaneous in_valid, so that bit is dropped and err_sel is not raised.
- data_out word k holds its value until the next completed word on channel k.
- Outputs are fully registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro DEMUX_PARITY_EN.
- Defined:
  - Adds output out_parity, width NUM_OUT.
  - out_parity[k] = XOR of the word loaded into data_out word k (even-parity bit), registered in the same cycle as data_out.
  - Reset value is 0; it is held with data_out.
- Undefined: no out_parity port and no parity logic. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-stream after 3 bits on ch0 -> all outputs 0 immediately. After release, 8 bits 1010_0101 on ch0 -> data_out[7:0]=8'hA5 and out_valid=4'b0001 for exactly 1 cycle, 1 cycle after the 8th bit.
- Interleave: 4 bits 1100 to ch1, then 8 bits 0xFF to ch2, then 4 bits 0011 to ch1 -> ch2 word=8'hFF pulses first; ch1 word=8'hC3 pulses later; ch0 and ch3 unchanged.
- Back-to-back: 16 consecutive valid bits 0x3C then 0x81 on ch3 -> two out_valid[3] pulses 8 cycles apart; final data_out[31:24]=8'h81.
- Flush: 5 bits on ch0, then flush=1 with in_valid=1 in the same cycle, then 8 bits 0x5A -> no pulse before the 8th post-flush bit; word=8'h5A; err_sel stays 0.
- Out of range: NUM_OUT=3, select=3, in_valid=1 for 2 cycles -> err_sel high 2 cycles; no counter advance; next 8 bits on ch0 give the exact word sent.
- Parity (DEMUX_PARITY_EN): word 0x07 on ch1 -> out_parity[1]=1; word 0x03 on ch1 -> out_parity[1]=0.
